// File: rtl/data_memory.sv
// data_memory: byte-addressable data RAM with funct3 load/store extension.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word accesses.
module data_memory #(
    parameter int size  = 32,
    parameter int DEPTH = 1024
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] addr_i,
    input  logic [size-1:0] data_i,
    input  logic [2:0]      control_i,
    input  logic            rw_i,
    output logic [size-1:0] data_o,
    output logic            fault_o,
    output logic            err_sticky_o,
    output logic [size-1:0] fault_addr_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [31:0]   rd_word;
    logic [31:0]   ld_val;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          illegal;
    logic          misalign;
    logic          fault;
    logic          unused_bits;

    assign idx         = addr_i[AW+1:2];
    assign off         = addr_i[1:0];
    assign rd_word     = mem[idx];
    assign unused_bits = ^{addr_i, data_i};

    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        is_word = 1'b0;
        illegal = 1'b0;
        unique case (control_i)
            3'b000, 3'b100: is_byte = 1'b1;
            3'b001, 3'b101: is_half = 1'b1;
            3'b010:         is_word = 1'b1;
            default:        illegal = 1'b1;
        endcase
        // unsigned variants have no store meaning
        if (rw_i && control_i[2])
            illegal = 1'b1;
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (is_half && off[0]) || (is_word && (off != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    assign fault   = illegal | misalign;
    assign fault_o = fault;

    assign ld_byte = rd_word[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        ld_val = '0;
        unique case (1'b1)
            is_byte: ld_val = control_i[2] ? {24'b0, ld_byte}
                                           : {{24{ld_byte[7]}}, ld_byte};
            is_half: ld_val = control_i[2] ? {16'b0, ld_half}
                                           : {{16{ld_half[15]}}, ld_half};
            is_word: ld_val = rd_word;
            default: ld_val = '0;
        endcase
        if (fault)
            ld_val = '0;
    end

    assign data_o = size'(ld_val);

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = data_i[31:0];
        unique case (1'b1)
            is_byte: begin
                wr_be   = 4'b0001 << off;
                wr_data = {4{data_i[7:0]}};
            end
            is_half: begin
                wr_be   = off[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{data_i[15:0]}};
            end
            is_word: wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    // array is intentionally left out of reset
    always_ff @(posedge clk) begin
        if (reset && rw_i && !fault) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i])
                    mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_sticky_o <= 1'b0;
            fault_addr_o <= '0;
        end else if (fault) begin
            err_sticky_o <= 1'b1;
            fault_addr_o <= addr_i;
        end
    end

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed and random checks of data_memory against a
// byte-array reference model.
module tb_data_memory;

    localparam int DEPTH = 1024;
    localparam int NB    = 4 * DEPTH;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [2:0]  control_i;
    logic        rw_i;
    logic [31:0] data_o;
    logic        fault_o;
    logic        err_sticky_o;
    logic [31:0] fault_addr_o;

    int total = 0;
    int fails = 0;

    logic [7:0]  rmem [NB];
    logic        m_sticky;
    logic [31:0] m_faddr;
    logic [31:0] last_data;
    logic        last_fault;

    data_memory #(
        .size (32),
        .DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr_i      (addr_i),
        .data_i      (data_i),
        .control_i   (control_i),
        .rw_i        (rw_i),
        .data_o      (data_o),
        .fault_o     (fault_o),
        .err_sticky_o(err_sticky_o),
        .fault_addr_o(fault_addr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] c);
        if (c[1:0] == 2'b00) return 1;
        if (c[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit m_fault(input logic [31:0] a, input logic [2:0] c,
                                   input logic w);
        bit legal;
        bit mis;
        legal = (c == 3'd0 || c == 3'd1 || c == 3'd2 ||
                 c == 3'd4 || c == 3'd5) && !(w && c[2]);
        mis = (nbytes(c) == 2 && a[0]) || (nbytes(c) == 4 && a[1:0] != 0);
        return !legal || (TRAP && mis);
    endfunction

    function automatic logic [31:0] m_base(input logic [31:0] a,
                                           input logic [2:0] c);
        logic [31:0] b;
        b = a % NB;
        return b - (b % nbytes(c));
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a,
                                           input logic [2:0] c,
                                           input logic w);
        logic [31:0] v;
        logic [31:0] b;
        int n;
        if (m_fault(a, c, w)) return 32'h0;
        n = nbytes(c);
        b = m_base(a, c);
        v = 32'h0;
        for (int i = 0; i < n; i++)
            v = v | (32'(rmem[b + i]) << (8 * i));
        if (!c[2] && n < 4 && v[8*n-1])
            v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic op(input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] c, input logic w, input bit check);
        logic [31:0] b;
        bit f;
        addr_i    = a;
        data_i    = d;
        control_i = c;
        rw_i      = w;
        #2;
        last_data  = data_o;
        last_fault = fault_o;
        f = m_fault(a, c, w);
        if (check) begin
            chk("data_o", data_o, m_load(a, c, w));
            chk("fault_o", {31'b0, fault_o}, {31'b0, f});
        end
        @(posedge clk);
        if (reset) begin
            if (f) begin
                m_sticky = 1'b1;
                m_faddr  = a;
            end else if (w) begin
                b = m_base(a, c);
                for (int i = 0; i < nbytes(c); i++)
                    rmem[b + i] = d[8*i +: 8];
            end
        end
        #1;
        if (check) begin
            chk("err_sticky_o", {31'b0, err_sticky_o}, {31'b0, m_sticky});
            chk("fault_addr_o", fault_addr_o, m_faddr);
        end
    endtask

    initial begin
        reset     = 1'b1;
        addr_i    = 32'h0;
        data_i    = 32'h0;
        control_i = 3'b010;
        rw_i      = 1'b0;
        m_sticky  = 1'b0;
        m_faddr   = 32'h0;
        #1 reset  = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_sticky", {31'b0, err_sticky_o}, 32'h0);
        chk("rst_faddr", fault_addr_o, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < DEPTH; i++)
            op(32'(i * 4), $urandom, 3'b010, 1'b1, 1'b0);

        op(32'h10, 32'hDEADBEEF, 3'b010, 1'b1, 1'b1);
        op(32'h10, 32'h0, 3'b010, 1'b0, 1'b1);
        chk("sw_lw", last_data, 32'hDEADBEEF);
        chk("sw_lw_fault", {31'b0, last_fault}, 32'h0);

        op(32'h10, 32'h11223344, 3'b010, 1'b1, 1'b1);
        op(32'h13, 32'h00000080, 3'b000, 1'b1, 1'b1);
        op(32'h10, 32'h0, 3'b010, 1'b0, 1'b1);
        chk("sb_lw", last_data, 32'h80223344);
        op(32'h13, 32'h0, 3'b000, 1'b0, 1'b1);
        chk("lb", last_data, 32'hFFFFFF80);
        op(32'h13, 32'h0, 3'b100, 1'b0, 1'b1);
        chk("lbu", last_data, 32'h00000080);

        op(32'h20, 32'h80017FFF, 3'b010, 1'b1, 1'b1);
        op(32'h22, 32'h0, 3'b001, 1'b0, 1'b1);
        chk("lh_hi", last_data, 32'hFFFF8001);
        op(32'h22, 32'h0, 3'b101, 1'b0, 1'b1);
        chk("lhu_hi", last_data, 32'h00008001);
        op(32'h20, 32'h0, 3'b001, 1'b0, 1'b1);
        chk("lh_lo", last_data, 32'h00007FFF);

        op(32'h21, 32'hCAFEF00D, 3'b010, 1'b1, 1'b1);
        if (TRAP) begin
            chk("mis_fault", {31'b0, last_fault}, 32'h1);
            chk("mis_sticky", {31'b0, err_sticky_o}, 32'h1);
            chk("mis_faddr", fault_addr_o, 32'h21);
            op(32'h20, 32'h0, 3'b010, 1'b0, 1'b1);
            chk("mis_nowrite", last_data, 32'h80017FFF);
        end else begin
            chk("mis_fault", {31'b0, last_fault}, 32'h0);
            op(32'h20, 32'h0, 3'b010, 1'b0, 1'b1);
            chk("mis_aligned", last_data, 32'hCAFEF00D);
        end

        op(32'h40, 32'hFFFFFFFF, 3'b011, 1'b1, 1'b1);
        chk("ill_fault", {31'b0, last_fault}, 32'h1);
        chk("ill_data", last_data, 32'h0);
        chk("ill_sticky", {31'b0, err_sticky_o}, 32'h1);
        chk("ill_faddr", fault_addr_o, 32'h40);
        op(32'h40, 32'h0, 3'b010, 1'b0, 1'b1);

        #2 reset = 1'b0;
        m_sticky = 1'b0;
        m_faddr  = 32'h0;
        #1;
        chk("async_sticky", {31'b0, err_sticky_o}, 32'h0);
        chk("async_faddr", fault_addr_o, 32'h0);
        @(posedge clk);
        #1;
        op(32'h80, 32'h12345678, 3'b010, 1'b1, 1'b1);
        op(32'h7E, 32'h0, 3'b011, 1'b0, 1'b1);
        chk("rst_hold_sticky", {31'b0, err_sticky_o}, 32'h0);
        reset = 1'b1;
        op(32'h84, 32'hA5A5A5A5, 3'b010, 1'b1, 1'b1);
        op(32'h84, 32'h0, 3'b010, 1'b0, 1'b1);
        chk("rel_store", last_data, 32'hA5A5A5A5);
        op(32'h80, 32'h0, 3'b010, 1'b0, 1'b1);

        op(32'h1000, 32'd5, 3'b010, 1'b1, 1'b1);
        op(32'h0, 32'h0, 3'b010, 1'b0, 1'b1);
        chk("wrap", last_data, 32'd5);
        op(32'h0, 32'd9, 3'b010, 1'b1, 1'b1);
        chk("collide_old", last_data, 32'd5);
        op(32'h0, 32'h0, 3'b010, 1'b0, 1'b1);
        chk("collide_new", last_data, 32'd9);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 63));
            op(a, $urandom, 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 1'b1);
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The module SHALL have parameter size, default 32, meaning the data and address width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the array (power of two).
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-005 The module SHALL have port addr_i, input, size bits, the byte address (ALU result forwarded by the MEM stage).
REQ-006 The module SHALL have port data_i, input, size bits, the store data.
REQ-007 The module SHALL have port control_i, input, 3 bits, the funct3 access type.
REQ-008 The module SHALL have port rw_i, input, 1 bit; 1 = store this cycle, 0 = no write.
REQ-009 The module SHALL have port data_o, output, size bits, the extended load result.
REQ-010 The module SHALL have port fault_o, output, 1 bit, the combinational access-fault indication for the current access.
REQ-011 The module SHALL have port err_sticky_o, output, 1 bit, the registered sticky fault flag.
REQ-012 The module SHALL have port fault_addr_o, output, size bits, the registered address of the most recent faulting access.

Function
REQ-013 The word index SHALL be addr_i[log2(DEPTH)+1:2]; upper address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH.
REQ-014 The control_i encodings SHALL be: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 011, 110 and 111 SHALL be illegal.
REQ-015 Loads SHALL be combinational from the array: lane selected by addr_i[1:0], sign-extended for 000/001 and zero-extended for 100/101.
REQ-016 Stores SHALL write on the clk rising edge when rw_i=1, updating only the addressed byte lanes (byte: 1 lane, half: 2 lanes, word: 4 lanes).
REQ-017 For stores, data_i[7:0] SHALL be placed in the byte lane and data_i[15:0] in the half lanes; control 100/101 with rw_i=1 SHALL be treated as illegal.
REQ-018 A load and store to the same word in the same cycle SHALL return the pre-write data on data_o.
REQ-019 An illegal encoding SHALL assert fault_o, force data_o=0, and suppress any write.
REQ-020 The array SHALL NOT be reset; its contents after power-up are undefined.
REQ-021 Whenever fault_o=1 at a clk rising edge, err_sticky_o SHALL become 1 and fault_addr_o SHALL load addr_i.
REQ-022 err_sticky_o SHALL clear only on reset.
REQ-023 Back-to-back faults SHALL each overwrite fault_addr_o, so the last fault wins.

Reset
REQ-024 While reset=0, err_sticky_o=0 and fault_addr_o=0, asynchronously, regardless of clk.
REQ-025 Writes SHALL be suppressed while reset=0.
REQ-026 A store coincident with reset deassertion SHALL occur at the first rising edge with reset=1.
REQ-027 data_o and fault_o SHALL remain combinational functions of the inputs and array during reset.

Configuration
REQ-028 The macro DMEM_MISALIGN_TRAP_EN SHALL control misaligned-access handling (half with addr_i[0]=1, word with addr_i[1:0]!=00).
REQ-029 With DMEM_MISALIGN_TRAP_EN defined, a misaligned access SHALL assert fault_o, force data_o=0, suppress the write, and update the sticky and address registers per REQ-021.
REQ-030 Without DMEM_MISALIGN_TRAP_EN, misaligned addresses SHALL be silently aligned down (half: addr_i[0] ignored; word: addr_i[1:0] ignored), with no fault; only illegal encodings fault.

Verification
REQ-031 Store word: reset released; SW addr=0x10 data=0xDEADBEEF; next cycle LW addr=0x10 -> data_o=0xDEADBEEF, fault_o=0.
REQ-032 Byte store and loads: SB addr=0x13 data=0x00000080 over 0x11223344 -> LW gives 0x80223344; LB 0x13 gives 0xFFFFFF80; LBU 0x13 gives 0x00000080.
REQ-033 Half loads: word 0x8001_7FFF at 0x20 -> LH 0x22 gives 0xFFFF8001; LHU 0x22 gives 0x00008001; LH 0x20 gives 0x00007FFF.
REQ-034 Misalign with macro: SW addr=0x21 -> fault_o=1, memory unchanged, next edge err_sticky_o=1, fault_addr_o=0x21. Without macro: the store writes word 0x20, fault_o=0.
REQ-035 Illegal encoding and reset: control=011 rw_i=1 at 0x40 -> no write, fault_o=1, fault_addr_o=0x40. Then assert reset mid-cycle -> err_sticky_o and fault_addr_o are 0 immediately.
REQ-036 Wrap and collision: DEPTH=1024, SW addr=0x1000 data=5 -> LW 0x0 gives 5. Same-cycle SW/LW to 0x0 with new data 9 -> data_o=5 that cycle and 9 the next.
